// File: rtl/cheat_loader_pkg.sv
// Shared state encoding, error codes and record framing constants for the
// cheat engine programming-port loader.
package cheat_loader_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_COUNT,
    S_IDX,
    S_DATA,
    S_WRITE,
    S_CSUM,
    S_FLUSH,
    S_DONE,
    S_ERR
  } state_t;

  localparam logic [1:0] ERR_NONE  = 2'd0;
  localparam logic [1:0] ERR_COUNT = 2'd1;
  localparam logic [1:0] ERR_INDEX = 2'd2;
  localparam logic [1:0] ERR_CSUM  = 2'd3;

  localparam int         DATA_BYTES     = 4;
  localparam logic [1:0] LAST_DATA_BYTE = 2'(DATA_BYTES - 1);

endpackage

// File: rtl/cheat_loader_stage.sv
// In-order staging buffer holding {idx, word} records until the frame
// checksum has been verified; i_clr discards everything.
module cheat_loader_stage #(
  parameter int DEPTH = 8,
  parameter int W     = 35
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_clr,
  input  logic         i_push,
  input  logic [W-1:0] i_wdata,
  input  logic         i_pop,
  output logic [W-1:0] o_rdata,
  output logic         o_empty,
  output logic         o_full
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [W-1:0]     r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;
  assign o_rdata = r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_push && !rst && !i_clr) r_mem[r_wr_ptr] <= i_wdata;
  end

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= next_ptr(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= next_ptr(r_rd_ptr);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/cheat_loader.sv
// Frames MCU bytes into 32-bit cheat entries and writes them to the engine's
// pgm port, holding off while the SNES side owns it. CHEAT_LOADER_CSUM_EN adds a checksum stage.
module cheat_loader
  import cheat_loader_pkg::*;
#(
  parameter int NUM_ENTRIES = 8,
  parameter int IDX_W       = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_start,
  input  logic [7:0]       byte_in,
  input  logic             byte_valid,
  output logic             byte_ready,
  input  logic             pgm_busy_in,
  output logic [IDX_W-1:0] pgm_idx,
  output logic             pgm_we,
  output logic [31:0]      pgm_in,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [1:0]       err_code,
  output state_t           dbg_state
);

  localparam int CNT_W = $clog2(NUM_ENTRIES + 1);

  // Handshake: a byte moves on a clk edge where byte_valid & byte_ready;
  // byte_ready drops whenever cmd_start is high so an aborting byte is never taken.
  state_t           r_state;
  logic [IDX_W-1:0] r_idx;
  logic [31:0]      r_word;
  logic [CNT_W-1:0] r_remain;
  logic [1:0]       r_bcnt;
  logic             r_err;
  logic [1:0]       r_err_code;

  logic        w_accept;
  logic        w_we;
  logic        w_cnt_bad;
  logic        w_idx_bad;
  logic [31:0] w_word_next;

  assign byte_ready  = (r_state inside {S_COUNT, S_IDX, S_DATA, S_CSUM}) & ~cmd_start;
  assign w_accept    = byte_valid & byte_ready;
  assign w_we        = (r_state == S_WRITE) & ~pgm_busy_in & ~cmd_start;
  assign w_word_next = {r_word[23:0], byte_in};
  assign w_cnt_bad   = (byte_in == 8'd0) || ({24'd0, byte_in} > 32'(NUM_ENTRIES));
  assign w_idx_bad   = ({24'd0, byte_in} >= 32'(NUM_ENTRIES));

`ifdef CHEAT_LOADER_CSUM_EN
  logic [7:0]          r_csum;
  logic                w_push;
  logic                w_pop;
  logic                w_st_empty;
  logic                w_st_full;
  logic [IDX_W+31:0]   w_st_rdata;

  assign w_push = w_accept & (r_state == S_DATA) & (r_bcnt == LAST_DATA_BYTE) & ~w_st_full;
  assign w_pop  = (r_state == S_FLUSH) & ~cmd_start;

  cheat_loader_stage #(
    .DEPTH (NUM_ENTRIES),
    .W     (IDX_W + 32)
  ) u_stage (
    .clk     (clk),
    .rst     (rst),
    .i_clr   (cmd_start),
    .i_push  (w_push),
    .i_wdata ({r_idx, w_word_next}),
    .i_pop   (w_pop),
    .o_rdata (w_st_rdata),
    .o_empty (w_st_empty),
    .o_full  (w_st_full)
  );
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_idx      <= '0;
      r_word     <= '0;
      r_remain   <= '0;
      r_bcnt     <= '0;
      r_err      <= 1'b0;
      r_err_code <= ERR_NONE;
`ifdef CHEAT_LOADER_CSUM_EN
      r_csum     <= '0;
`endif
    end else if (cmd_start) begin
      r_state    <= S_COUNT;
      r_remain   <= '0;
      r_bcnt     <= '0;
      r_err      <= 1'b0;
      r_err_code <= ERR_NONE;
`ifdef CHEAT_LOADER_CSUM_EN
      r_csum     <= '0;
`endif
    end else begin
`ifdef CHEAT_LOADER_CSUM_EN
      if (w_accept) r_csum <= r_csum ^ byte_in;
`endif
      unique case (r_state)
        S_COUNT: if (w_accept) begin
          if (w_cnt_bad) begin
            r_state    <= S_ERR;
            r_err      <= 1'b1;
            r_err_code <= ERR_COUNT;
          end else begin
            r_remain <= byte_in[CNT_W-1:0];
            r_state  <= S_IDX;
          end
        end
        S_IDX: if (w_accept) begin
          if (w_idx_bad) begin
            r_state    <= S_ERR;
            r_err      <= 1'b1;
            r_err_code <= ERR_INDEX;
          end else begin
            r_idx   <= byte_in[IDX_W-1:0];
            r_bcnt  <= '0;
            r_state <= S_DATA;
          end
        end
        S_DATA: if (w_accept) begin
          r_word <= w_word_next;
          r_bcnt <= r_bcnt + 2'd1;
          if (r_bcnt == LAST_DATA_BYTE) begin
`ifdef CHEAT_LOADER_CSUM_EN
            r_remain <= r_remain - CNT_W'(1);
            r_state  <= (r_remain == CNT_W'(1)) ? S_CSUM : S_IDX;
`else
            r_state  <= S_WRITE;
`endif
          end
        end
        S_WRITE: if (w_we) begin
`ifdef CHEAT_LOADER_CSUM_EN
          r_state <= w_st_empty ? S_DONE : S_FLUSH;
`else
          r_remain <= r_remain - CNT_W'(1);
          r_state  <= (r_remain == CNT_W'(1)) ? S_DONE : S_IDX;
`endif
        end
`ifdef CHEAT_LOADER_CSUM_EN
        S_CSUM: if (w_accept) begin
          if (byte_in == r_csum) begin
            r_state <= S_FLUSH;
          end else begin
            r_state    <= S_ERR;
            r_err      <= 1'b1;
            r_err_code <= ERR_CSUM;
          end
        end
        // Each staged record is loaded here, then goes through WRITE's holdoff.
        S_FLUSH: begin
          {r_idx, r_word} <= w_st_rdata;
          r_state         <= S_WRITE;
        end
`endif
        S_DONE:  r_state <= S_IDLE;
        S_IDLE:  ;
        S_ERR:   ;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign pgm_we    = w_we;
  assign pgm_idx   = r_idx;
  assign pgm_in    = r_word;
  assign busy      = !(r_state inside {S_IDLE, S_DONE, S_ERR});
  assign done      = (r_state == S_DONE);
  assign err       = r_err;
  assign err_code  = r_err_code;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_cheat_loader.sv
// Bench for cheat_loader: reset checks, a directed frame table, hand-built
// timing/abort sequences and random frames against a frame-level model.
module tb_cheat_loader;
  import cheat_loader_pkg::*;

  localparam int NUM = 8;
  localparam int IW  = 3;
  localparam int W   = IW + 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_start;
  logic [7:0]    byte_in;
  logic          byte_valid;
  logic          byte_ready;
  logic          pgm_busy_in;
  logic [IW-1:0] pgm_idx;
  logic          pgm_we;
  logic [31:0]   pgm_in;
  logic          busy;
  logic          done;
  logic          err;
  logic [1:0]    err_code;
  state_t        dbg_state;

  int       n_cmp    = 0;
  int       n_fail   = 0;
  int       done_cnt = 0;
  bit       rand_busy = 1'b0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] act_q[$];

  typedef struct {
    logic [7:0]   b[12];
    int           len;
    logic [1:0]   code;
    int           nwr;
    logic [W-1:0] last;
  } vec_t;

  cheat_loader #(.NUM_ENTRIES(NUM), .IDX_W(IW)) dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_start   (cmd_start),
    .byte_in     (byte_in),
    .byte_valid  (byte_valid),
    .byte_ready  (byte_ready),
    .pgm_busy_in (pgm_busy_in),
    .pgm_idx     (pgm_idx),
    .pgm_we      (pgm_we),
    .pgm_in      (pgm_in),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .err_code    (err_code),
    .dbg_state   (dbg_state)
  );

  // clock / reset block
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst) begin
      if (pgm_we) act_q.push_back({pgm_idx, pgm_in});
      if (done) done_cnt++;
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (rand_busy) pgm_busy_in = ($urandom_range(0, 2) == 0);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // driver tasks
  task automatic start_frame();
    act_q.delete();
    done_cnt   = 0;
    cmd_start  = 1'b1;
    byte_valid = 1'b0;
    step();
    cmd_start  = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    bit acc = 1'b0;
    if (gaps) repeat ($urandom_range(0, 2)) step();
    byte_in    = b;
    byte_valid = 1'b1;
    for (int t = 0; t < 100 && !acc; t++) begin
      @(negedge clk);
      acc = byte_ready;
      step();
    end
    byte_valid = 1'b0;
    check("byte_accept", acc, 1);
  endtask

  task automatic wait_idle();
    bit idle = 1'b0;
    for (int t = 0; t < 400 && !idle; t++) begin
      @(negedge clk);
      idle = !busy;
      if (!idle) step();
    end
    step();
    step();
    check("idle_reached", idle, 1);
  endtask

  // Cycles from the current point until pgm_we; pgm_busy_in released after 'hold' cycles.
  task automatic lat_to_we(input int hold, output int lat);
    bit found = 1'b0;
    lat = 0;
    for (int c = 0; c < 20 && !found; c++) begin
      if (c == hold) pgm_busy_in = 1'b0;
      @(negedge clk);
      if (pgm_we) found = 1'b1;
      else begin
        lat++;
        step();
      end
    end
    step();
    check("we_seen", found, 1);
  endtask

  // Frame-level reference: expected writes into exp_q, bytes the loader will take, final err_code.
  function automatic void model(input logic [7:0] fr[$], output int n_use, output logic [1:0] code);
    int n;
    logic [7:0] x;
    exp_q.delete();
    code  = 2'd0;
    n     = int'(fr[0]);
    n_use = 1;
    if (n < 1 || n > NUM) begin
      code = 2'd1;
      return;
    end
    for (int r = 0; r < n; r++) begin
      if (int'(fr[n_use]) >= NUM) begin
        code = 2'd2;
        n_use++;
`ifdef CHEAT_LOADER_CSUM_EN
        exp_q.delete();
`endif
        return;
      end
      exp_q.push_back({fr[n_use][IW-1:0], fr[n_use+1], fr[n_use+2], fr[n_use+3], fr[n_use+4]});
      n_use += 5;
    end
`ifdef CHEAT_LOADER_CSUM_EN
    x = 8'h00;
    for (int i = 0; i < n_use; i++) x ^= fr[i];
    if (fr[n_use] != x) begin
      code = 2'd3;
      exp_q.delete();
    end
    n_use++;
`endif
  endfunction

  task automatic run_random_frame();
    logic [7:0] fr[$];
    logic [7:0] x;
    int r, n, n_use;
    logic [1:0] code;
    r = $urandom_range(0, 19);
    n = (r == 0) ? 0 : (r == 1) ? NUM + 1 : $urandom_range(1, NUM);
    fr.push_back(8'(n));
    if (n >= 1 && n <= NUM) begin
      for (int k = 0; k < n; k++) begin
        fr.push_back(($urandom_range(0, 24) == 0) ? 8'(NUM + $urandom_range(0, 3)) : 8'($urandom_range(0, NUM - 1)));
        for (int j = 0; j < 4; j++) fr.push_back(8'($urandom_range(0, 255)));
      end
    end
    x = 8'h00;
    foreach (fr[i]) x ^= fr[i];
    fr.push_back(($urandom_range(0, 7) == 0) ? (x ^ 8'h5A) : x);
    model(fr, n_use, code);
    start_frame();
    for (int i = 0; i < n_use; i++) send_byte(fr[i], 1'b1);
    wait_idle();
    check("rnd_err_code", err_code, code);
    check("rnd_err", err, (code != 2'd0));
    check("rnd_done_cnt", done_cnt, (code == 2'd0));
    check("rnd_wr_cnt", act_q.size(), exp_q.size());
    foreach (exp_q[i]) if (i < act_q.size()) check("rnd_wr_rec", act_q[i], exp_q[i]);
  endtask

  vec_t vt[6];

  initial begin
    int lat;

`ifdef CHEAT_LOADER_CSUM_EN
    vt[0] = '{'{8'h01, 8'h07, 8'h00, 8'h00, 8'h3F, 8'h00, 8'h39, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 7, 2'd0, 1, {3'd7, 32'h00003F00}};
    vt[1] = '{'{8'h01, 8'h07, 8'h00, 8'h00, 8'h3F, 8'h00, 8'h38, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 7, 2'd3, 0, '0};
    vt[2] = '{'{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 1, 2'd1, 0, '0};
    vt[3] = '{'{8'h09, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 1, 2'd1, 0, '0};
    vt[4] = '{'{8'h01, 8'h08, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 2, 2'd2, 0, '0};
    vt[5] = '{'{8'h01, 8'h02, 8'h12, 8'h34, 8'h56, 8'hAA, 8'hD9, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 7, 2'd0, 1, {3'd2, 32'h123456AA}};
`else
    vt[0] = '{'{8'h01, 8'h02, 8'h12, 8'h34, 8'h56, 8'hAA, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 6, 2'd0, 1, {3'd2, 32'h123456AA}};
    vt[1] = '{'{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 1, 2'd1, 0, '0};
    vt[2] = '{'{8'h09, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 1, 2'd1, 0, '0};
    vt[3] = '{'{8'h01, 8'h08, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 2, 2'd2, 0, '0};
    vt[4] = '{'{8'h02, 8'h00, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h07, 8'h01, 8'h02, 8'h03, 8'h04, 8'h00}, 11, 2'd0, 2, {3'd7, 32'h01020304}};
    vt[5] = '{'{8'h02, 8'h03, 8'h11, 8'h22, 8'h33, 8'h44, 8'h03, 8'h55, 8'h66, 8'h77, 8'h88, 8'h00}, 11, 2'd0, 2, {3'd3, 32'h55667788}};
`endif

    rst         = 1'b1;
    cmd_start   = 1'b0;
    byte_valid  = 1'b0;
    byte_in     = 8'h00;
    pgm_busy_in = 1'b0;
    repeat (3) step();
    check("rst_byte_ready", byte_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_pgm_we", pgm_we, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_err_code", err_code, 0);
    check("rst_pgm_idx", pgm_idx, 0);
    check("rst_pgm_in", pgm_in, 0);
    rst = 1'b0;
    step();
    check("idle_byte_ready", byte_ready, 0);

    for (int v = 0; v < 6; v++) begin
      start_frame();
      for (int i = 0; i < vt[v].len; i++) send_byte(vt[v].b[i], 1'b0);
      wait_idle();
      check("vec_err_code", err_code, vt[v].code);
      check("vec_err", err, (vt[v].code != 2'd0));
      check("vec_wr_cnt", act_q.size(), vt[v].nwr);
      check("vec_done_cnt", done_cnt, (vt[v].code == 2'd0));
      check("vec_busy", busy, 0);
      if (vt[v].nwr > 0 && act_q.size() > 0) check("vec_last_wr", act_q[act_q.size()-1], vt[v].last);
      if (vt[v].code != 2'd0) begin
        step();
        check("err_ready_low", byte_ready, 0);
      end
    end

`ifndef CHEAT_LOADER_CSUM_EN
    // Basic write: pgm_we in the cycle right after B3 is taken.
    start_frame();
    foreach (vt[0].b[i]) if (i < 5) send_byte(vt[0].b[i], 1'b0);
    send_byte(8'hAA, 1'b0);
    lat_to_we(0, lat);
    check("basic_latency", lat, 0);
    wait_idle();
    check("basic_wr_cnt", act_q.size(), 1);
    if (act_q.size() > 0) check("basic_wr", act_q[0], {3'd2, 32'h123456AA});
    check("basic_done", done_cnt, 1);

    // Busy holdoff: engine blocked 3 cycles on each WRITE entry.
    start_frame();
    send_byte(8'h02, 1'b0);
    send_byte(8'h01, 1'b0);
    send_byte(8'hA1, 1'b0);
    send_byte(8'hA2, 1'b0);
    send_byte(8'hA3, 1'b0);
    pgm_busy_in = 1'b1;
    send_byte(8'hA4, 1'b0);
    lat_to_we(3, lat);
    check("hold1_latency", lat, 3);
    send_byte(8'h05, 1'b0);
    send_byte(8'hB1, 1'b0);
    send_byte(8'hB2, 1'b0);
    send_byte(8'hB3, 1'b0);
    pgm_busy_in = 1'b1;
    send_byte(8'hB4, 1'b0);
    lat_to_we(3, lat);
    check("hold2_latency", lat, 3);
    wait_idle();
    check("hold_wr_cnt", act_q.size(), 2);
    if (act_q.size() > 1) begin
      check("hold_wr0", act_q[0], {3'd1, 32'hA1A2A3A4});
      check("hold_wr1", act_q[1], {3'd5, 32'hB1B2B3B4});
    end
    check("hold_done", done_cnt, 1);

    // cmd_start landing on a WRITE cycle suppresses the write.
    start_frame();
    send_byte(8'h01, 1'b0);
    send_byte(8'h03, 1'b0);
    send_byte(8'hAA, 1'b0);
    send_byte(8'hBB, 1'b0);
    send_byte(8'hCC, 1'b0);
    send_byte(8'hDD, 1'b0);
    cmd_start = 1'b1;
    @(negedge clk);
    check("abort_we_suppressed", pgm_we, 0);
    step();
    cmd_start = 1'b0;
    repeat (3) step();
    check("abort_write_none", act_q.size(), 0);
    check("abort_write_state", dbg_state, S_COUNT);
`endif

    // Abort mid-record 2 with a byte offered in the same cycle.
    start_frame();
    send_byte(8'h02, 1'b0);
    send_byte(8'h01, 1'b0);
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    send_byte(8'h33, 1'b0);
    send_byte(8'h44, 1'b0);
    send_byte(8'h06, 1'b0);
    send_byte(8'h55, 1'b0);
    send_byte(8'h66, 1'b0);
    byte_in    = 8'h77;
    byte_valid = 1'b1;
    cmd_start  = 1'b1;
    @(negedge clk);
    check("abort_ready_low", byte_ready, 0);
    step();
    cmd_start  = 1'b0;
    byte_valid = 1'b0;
    check("abort_state", dbg_state, S_COUNT);
    check("abort_err_clear", err, 0);
    repeat (4) step();
    check("abort_still_count", dbg_state, S_COUNT);
    check("abort_done", done_cnt, 0);
`ifdef CHEAT_LOADER_CSUM_EN
    check("abort_wr_cnt", act_q.size(), 0);
`else
    check("abort_wr_cnt", act_q.size(), 1);
    if (act_q.size() > 0) check("abort_wr0", act_q[0], {3'd1, 32'h11223344});
`endif

    rand_busy = 1'b1;
    for (int f = 0; f < 40; f++) run_random_frame();
    rand_busy = 1'b0;
    step();
    pgm_busy_in = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
